// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Two-source round-robin arbiter in front of the shared UART transmitter.
// A granted byte is latched and presented to uart_tx with TX_Data_Valid held
// high for the whole frame. The owner is released on TX_Done_Sig, or by a
// watchdog if the transmitter never reports completion. Every output is a
// flop, so downstream logic (the bit-rate counter enable in particular) sees
// glitch-free levels.

module uart_tx_arbiter #(
    parameter int              TO_W    = 12,
    parameter logic [TO_W-1:0] TIMEOUT = 12'd2000
) (
    input  logic       CLK,
    input  logic       RSTn,

    input  logic       Req0_Sig,
    input  logic [7:0] Req0_Data,
    output logic       Ack0_Sig,

    input  logic       Req1_Sig,
    input  logic [7:0] Req1_Data,
    output logic       Ack1_Sig,

    input  logic       TX_Done_Sig,
    output logic       TX_Data_Valid,
    output logic [7:0] TX_Data,

    output logic [1:0] Grant_Out,
    output logic       Timeout_Sig
);

    // Last counter value that may still be spent in SEND; reaching it without
    // a done pulse forces the release, so the counter can never wrap.
    localparam logic [TO_W-1:0] LAST_CNT = TIMEOUT - 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t          state_q,   state_d;
    logic            last_q,    last_d;      // requester served most recently
    logic [TO_W-1:0] cnt_q,     cnt_d;       // cycles spent in SEND
    logic [7:0]      tx_data_q, tx_data_d;
    logic            valid_q,   valid_d;
    logic [1:0]      grant_q,   grant_d;
    logic            ack0_q,    ack0_d;
    logic            ack1_q,    ack1_d;
    logic            timeout_q, timeout_d;

    // Arbitration result for the current IDLE cycle
    logic            any_req;
    logic            winner;                 // 0: requester 0, 1: requester 1

    // Pick the winner: a lone requester wins outright, a tie goes to the
    // requester that was not served last.
    always_comb begin
        any_req = Req0_Sig | Req1_Sig;
        if (Req0_Sig && Req1_Sig) begin
            winner = ~last_q;
        end else begin
            winner = Req1_Sig;
        end
    end

    // Next-state and next-output logic for the IDLE / SEND / DONE sequence.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the case statement can leave one unassigned and
        // infer a latch.
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        valid_d   = valid_q;
        grant_d   = grant_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // TX_Done_Sig is deliberately not looked at here.
                if (any_req) begin
                    state_d   = S_SEND;
                    last_d    = winner;
                    cnt_d     = '0;
                    tx_data_d = winner ? Req1_Data : Req0_Data;
                    grant_d   = winner ? 2'b10 : 2'b01;
                    valid_d   = 1'b1;
                end
            end

            S_SEND: begin
                // Requests and data are ignored while a frame is in flight;
                // a requester that drops out still gets its Ack.
                if (TX_Done_Sig) begin
                    // Normal completion wins over a coincident timeout.
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    grant_d = 2'b00;
                    ack0_d  = grant_q[0];
                    ack1_d  = grant_q[1];
                end else if (cnt_q == LAST_CNT) begin
                    state_d   = S_DONE;
                    valid_d   = 1'b0;
                    grant_d   = 2'b00;
                    ack0_d    = grant_q[0];
                    ack1_d    = grant_q[1];
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                // One cycle with valid low, then a further IDLE cycle: the
                // transmitter's bit-rate counter always sees a clean restart.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                grant_d = 2'b00;
            end
        endcase
    end

    // Register state and outputs; reset returns everything to idle at once,
    // dropping any frame in flight without an Ack.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
            valid_q   <= 1'b0;
            grant_q   <= 2'b00;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // values from before the edge, independent of statement order.
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            valid_q   <= valid_d;
            grant_q   <= grant_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            timeout_q <= timeout_d;
        end
    end

    assign TX_Data       = tx_data_q;
    assign TX_Data_Valid = valid_q;
    assign Grant_Out     = grant_q;
    assign Ack0_Sig      = ack0_q;
    assign Ack1_Sig      = ack1_q;
    assign Timeout_Sig   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter. A monitor pops expected frames from a queue on
// every rising TX_Data_Valid, checks data/owner, frame length, the Ack and
// Timeout pulses at release and the idle gap; it also plays the transmitter,
// pulsing TX_Done_Sig a programmable number of cycles into each frame.

module tb_uart_tx_arbiter;

    localparam int TIMEOUT_CYC = 2000;

    typedef struct {
        logic [1:0] grant;
        logic [7:0] data;
        int         len;      // cycles TX_Data_Valid stays high
        bit         forced;   // Timeout_Sig expected at release
    } exp_t;

    typedef struct {
        bit         r0;
        bit         r1;
        logic [7:0] d0;
        logic [7:0] d1;
        int         done_k;   // TX_Done_Sig this many cycles after valid rises; -1 = never
        bit         exp_owner;
        logic [7:0] exp_data;
        bit         exp_forced;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       ack0, ack1;
    logic       tx_done;
    logic       resp_done;
    logic       stray_done;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] grant;
    logic       timeout;

    int   n_cmp;
    int   n_fail;
    int   done_k;
    exp_t exp_q[$];
    vec_t vecs[8];

    assign tx_done = resp_done | stray_done;

    uart_tx_arbiter dut (
        .CLK          (clk),
        .RSTn         (rst_n),
        .Req0_Sig     (req0),
        .Req0_Data    (data0),
        .Ack0_Sig     (ack0),
        .Req1_Sig     (req1),
        .Req1_Data    (data1),
        .Ack1_Sig     (ack1),
        .TX_Done_Sig  (tx_done),
        .TX_Data_Valid(tx_valid),
        .TX_Data      (tx_data),
        .Grant_Out    (grant),
        .Timeout_Sig  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit owner, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = owner ? ack1 : ack0;
        end
        check(owner ? "ack1_wait" : "ack0_wait", seen, 1);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
        stray_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor / scoreboard and transmitter model
    initial begin : monitor
        bit   prev_valid;
        bit   in_frame;
        bit   rise;
        bit   fall;
        int   run_len;
        int   gap;
        int   resp_cnt;
        int   frames;
        exp_t cur;
        prev_valid = 1'b0; in_frame = 1'b0; run_len = 0; gap = 0;
        resp_cnt = 0; frames = 0; resp_done = 1'b0;
        cur = '{grant: 2'b00, data: 8'h00, len: 0, forced: 1'b0};
        forever begin
            tick();
            if (!rst_n) begin
                prev_valid = 1'b0; in_frame = 1'b0; frames = 0; gap = 0;
                resp_done = 1'b0;
            end else begin
                rise = tx_valid && !prev_valid;
                fall = !tx_valid && prev_valid;
                if (rise) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", tx_valid, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("frame_data", tx_data, cur.data);
                        check("frame_grant", grant, cur.grant);
                        if (frames > 0) check("idle_gap_ge2", gap >= 2, 1);
                    end
                    in_frame = 1'b1;
                    run_len  = 1;
                    resp_cnt = 0;
                    frames++;
                end else if (tx_valid && in_frame) begin
                    run_len++;
                    if (tx_data !== cur.data || grant !== cur.grant)
                        check("frame_hold", {grant, tx_data}, {cur.grant, cur.data});
                end
                if (fall && in_frame) begin
                    check("frame_len", run_len, cur.len);
                    check("ack0_at_release", ack0, cur.grant[0]);
                    check("ack1_at_release", ack1, cur.grant[1]);
                    check("timeout_at_release", timeout, cur.forced);
                    check("grant_idle", grant, 2'b00);
                    in_frame = 1'b0;
                    gap = 1;
                end else if (!tx_valid) begin
                    gap++;
                    if (ack0 || ack1 || timeout)
                        check("stray_pulse", {ack0, ack1, timeout}, 3'b000);
                end
                resp_done = tx_valid && (resp_cnt == done_k);
                if (tx_valid) resp_cnt++;
                prev_valid = tx_valid;
            end
        end
    end

    // Global bound on run time
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        n_cmp = 0; n_fail = 0; done_k = -1;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00; stray_done = 1'b0;

        // Table of single-frame cases, applied from reset (last pointer = 1)
        vecs[0] = '{1'b1, 1'b0, 8'h41, 8'h00,  520, 1'b0, 8'h41, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'hA5,   10, 1'b1, 8'hA5, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h22,    3, 1'b0, 8'h11, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h33, 8'h44,    0, 1'b1, 8'h44, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h55,   -1, 1'b1, 8'h55, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 8'h66, 8'h77,    5, 1'b0, 8'h66, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'h7E, 8'h00, 1999, 1'b0, 8'h7E, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h00,    2, 1'b1, 8'h00, 1'b0};

        // Reset state
        tick();
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_grant", grant, 2'b00);
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_timeout", timeout, 0);
        do_reset();

        // Simultaneous requests after reset: 0 first, then 1, two idle cycles apart
        done_k = 12;
        exp_q.push_back('{grant: 2'b01, data: 8'h31, len: 13, forced: 1'b0});
        exp_q.push_back('{grant: 2'b10, data: 8'h32, len: 13, forced: 1'b0});
        req0 = 1'b1; data0 = 8'h31; req1 = 1'b1; data1 = 8'h32;
        wait_ack(1'b0, 100);
        req0 = 1'b0;
        tick();
        check("gap_idle_cycle", tx_valid, 0);
        tick();
        check("second_grant_after_gap", {tx_valid, grant, tx_data}, {1'b1, 2'b10, 8'h32});
        wait_ack(1'b1, 100);
        req1 = 1'b0;
        tick();

        // Fairness: requester 1 held, requester 0 re-requests after each Ack
        done_k = 4;
        exp_q.push_back('{grant: 2'b01, data: 8'hA0, len: 5, forced: 1'b0});
        exp_q.push_back('{grant: 2'b10, data: 8'hB0, len: 5, forced: 1'b0});
        exp_q.push_back('{grant: 2'b01, data: 8'hA1, len: 5, forced: 1'b0});
        exp_q.push_back('{grant: 2'b10, data: 8'hB1, len: 5, forced: 1'b0});
        req0 = 1'b1; data0 = 8'hA0; req1 = 1'b1; data1 = 8'hB0;
        wait_ack(1'b0, 100);
        req0 = 1'b0; data0 = 8'hA1;
        tick();
        req0 = 1'b1;
        wait_ack(1'b1, 100);
        data1 = 8'hB1;
        wait_ack(1'b0, 100);
        req0 = 1'b0;
        wait_ack(1'b1, 100);
        req1 = 1'b0;
        tick();

        // Table-driven single frames
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            done_k = v.done_k;
            exp_q.push_back('{grant: v.exp_owner ? 2'b10 : 2'b01, data: v.exp_data,
                              len: v.exp_forced ? TIMEOUT_CYC : v.done_k + 1,
                              forced: v.exp_forced});
            req0 = v.r0; req1 = v.r1; data0 = v.d0; data1 = v.d1;
            tick();
            check("grant_latency", tx_valid, 1);
            // Loser withdraws; data changes during SEND must be ignored
            if (v.exp_owner) req0 = 1'b0; else req1 = 1'b0;
            data0 = ~data0; data1 = ~data1;
            wait_ack(v.exp_owner, TIMEOUT_CYC + 100);
            if (v.exp_owner) req1 = 1'b0; else req0 = 1'b0;
            tick();
        end

        // Reset mid-SEND with a pending request from requester 1
        done_k = -1;
        exp_q.push_back('{grant: 2'b01, data: 8'h99, len: 0, forced: 1'b0});
        req0 = 1'b1; data0 = 8'h99;
        tick();
        check("pre_reset_grant", grant, 2'b01);
        req1 = 1'b1; data1 = 8'h9A;
        repeat (10) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", tx_valid, 0);
        check("async_rst_data", tx_data, 8'h00);
        check("async_rst_grant", grant, 2'b00);
        check("async_rst_acks", {ack0, ack1, timeout}, 3'b000);
        repeat (3) tick();
        check("in_rst_acks", {ack0, ack1, timeout}, 3'b000);
        done_k = 6;
        exp_q.push_back('{grant: 2'b01, data: 8'h99, len: 7, forced: 1'b0});
        exp_q.push_back('{grant: 2'b10, data: 8'h9A, len: 7, forced: 1'b0});
        rst_n = 1'b1;
        tick();
        check("post_rst_req0_first", {tx_valid, grant}, {1'b1, 2'b01});
        wait_ack(1'b0, 100);
        req0 = 1'b0;
        wait_ack(1'b1, 100);
        req1 = 1'b0;
        tick();

        // Stray TX_Done_Sig in IDLE produces nothing
        tick();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        check("stray_done_no_ack", {ack0, ack1, timeout}, 3'b000);
        check("stray_done_no_valid", tx_valid, 0);
        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
